seq_divider: RTL



---
 rtl/div_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 16 +
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 129 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_N_DEFAULT = 8;
  localparam int DIV_MAX_W     = 32;

  // Magnitude of a sign-extended value, one bit wider so |-2^(W-1)| fits.
  function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] v);
    logic [DIV_MAX_W:0] e;
    e = {v[DIV_MAX_W-1], v};
    return e[DIV_MAX_W] ? (~e + 1'b1) : e;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/valid handshake bundle for the sequential divider.
interface seq_divider_if #(parameter int N = 8);

  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         valid;
  logic         busy;
  logic         dz;

  modport master (output start, X, Y, input Q, R, valid, busy, dz);
  modport slave  (input start, X, Y, output Q, R, valid, busy, dz);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0] rem_i,
  input  logic [N:0] dvd_i,
  input  logic [N:0] dsr_i,
  output logic [N:0] rem_o,
  output logic [N:0] dvd_o,
  output logic       qbit_o
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;
  logic         unusedTop;

  // Partial remainder stays below the divisor, so its top bit is never needed.
  assign unusedTop = rem_i[N] ^ dvd_i[N];

  always_comb begin
    shifted = {rem_i[N-1:0], dvd_i[N-1]};
    trial   = {1'b0, shifted} - {1'b0, dsr_i};
    qbit_o  = ~trial[N+1];
    rem_o   = qbit_o ? trial[N:0] : shifted;
    dvd_o   = {dvd_i[N-1:0], qbit_o};
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring signed divider, one quotient bit per clock.
// Optional DIV_EARLY_EXIT_EN: divide-by-zero / overflow skip the CALC phase.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(N);

  div_state_t   state_q;
  logic [CW-1:0] count_q;
  logic [N:0]   rem_q, dvd_q, dsr_q;
  logic [N-1:0] xOrig_q;
  logic         signQ_q, signR_q, zero_q, ovf_q;
  logic [N-1:0] q_q, r_q;
  logic         valid_q, busy_q, dz_q;

  logic [N-1:0] q_d, r_d;
  logic         dz_d;
  logic [N:0]   stepRem, stepDvd;
  logic         stepQbit;

  logic [DIV_MAX_W:0] absXW, absYW;
  logic               unusedHigh;
  logic               isZero, isOvf;

  // N must stay below DIV_MAX_W; the upper magnitude bits are always zero.
  assign absXW      = abs_ext(DIV_MAX_W'($signed(bus.X)));
  assign absYW      = abs_ext(DIV_MAX_W'($signed(bus.Y)));
  assign unusedHigh = ^{absXW[DIV_MAX_W:N+1], absYW[DIV_MAX_W:N+1]};
  assign isZero     = (bus.Y == '0);
  assign isOvf      = (bus.X == {1'b1, {(N-1){1'b0}}}) && (bus.Y == '1);

  div_step #(.N(N)) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dsr_i  (dsr_q),
    .rem_o  (stepRem),
    .dvd_o  (stepDvd),
    .qbit_o (stepQbit)
  );

  always_comb begin
    q_d  = signQ_q ? (~dvd_q[N-1:0] + 1'b1) : dvd_q[N-1:0];
    r_d  = signR_q ? (~rem_q[N-1:0] + 1'b1) : rem_q[N-1:0];
    dz_d = 1'b0;
    if (zero_q) begin
      q_d  = '1;
      r_d  = xOrig_q;
      dz_d = 1'b1;
    end else if (ovf_q) begin
      q_d = {1'b1, {(N-1){1'b0}}};
      r_d = '0;
    end
  end

  // Quotient bits accumulate in the low end of dvd_q as the dividend shifts out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      xOrig_q <= '0;
      signQ_q <= 1'b0;
      signR_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q   <= absXW[N:0];
            dsr_q   <= absYW[N:0];
            xOrig_q <= bus.X;
            signQ_q <= bus.X[N-1] ^ bus.Y[N-1];
            signR_q <= bus.X[N-1];
            zero_q  <= isZero;
            ovf_q   <= isOvf;
            rem_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
            state_q <= (isZero || isOvf) ? DONE : CALC;
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q   <= stepRem;
          dvd_q   <= stepDvd;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(N - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          q_q     <= q_d;
          r_q     <= r_d;
          dz_q    <= dz_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.dz    = dz_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule
